// File: rtl/tinyqv_fetch_buffer.sv
// Instruction fetch buffer: queues 16-bit halfwords from memory and presents
// 32-bit instructions with their PC to the decoder; flush redirects fetch.
module tinyqv_fetch_buffer #(
  parameter int PC_BITS = 24,
  parameter int DEPTH   = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic [PC_BITS-1:0] flush_pc_i,
  output logic               fetch_req_o,
  output logic [PC_BITS-1:0] fetch_addr_o,
  output logic               fetch_restart_o,
  input  logic [15:0]        fetch_data_i,
  input  logic               fetch_data_valid_i,
  output logic [31:0]        instr_o,
  output logic [PC_BITS-1:0] instr_pc_o,
  output logic               instr_valid_o,
  output logic               instr_illegal_o,
  input  logic               instr_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PAIR = CNT_W'(2);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {
    RESET_HOLD = 1'b0,
    RUN        = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_hi;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_BITS-1:0] fetch_addr_q, fetch_addr_d, instr_pc_q, instr_pc_d;
  logic               accept, consume;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_ptr_hi       = ptr_inc(rd_ptr_q);
  assign instr_o         = {mem_q[rd_ptr_hi], mem_q[rd_ptr_q]};
  assign instr_illegal_o = instr_valid_o && (mem_q[rd_ptr_q][1:0] != 2'b11);
  assign fetch_addr_o    = fetch_addr_q;
  assign instr_pc_o      = instr_pc_q;
  assign fetch_restart_o = flush_i;

  always_comb begin
    state_d       = state_q;
    fetch_req_o   = 1'b0;
    instr_valid_o = 1'b0;
    accept        = 1'b0;
    consume       = 1'b0;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_addr_d  = fetch_addr_q;
    instr_pc_d    = instr_pc_q;
    case (state_q)
      RESET_HOLD: state_d = RUN;
      RUN: begin
        fetch_req_o   = !flush_i && (count_q < FULL);
        instr_valid_o = !flush_i && (count_q >= PAIR);
        accept        = fetch_data_valid_i && fetch_req_o;
        consume       = instr_valid_o && instr_ready_i;
        if (flush_i) begin
          count_d      = '0;
          rd_ptr_d     = '0;
          wr_ptr_d     = '0;
          fetch_addr_d = {flush_pc_i[PC_BITS-1:2], 2'b00};
          instr_pc_d   = {flush_pc_i[PC_BITS-1:2], 2'b00};
        end else begin
          if (accept) begin
            wr_ptr_d     = ptr_inc(wr_ptr_q);
            fetch_addr_d = fetch_addr_q + PC_BITS'(2);
          end
          if (consume) begin
            rd_ptr_d   = ptr_inc(rd_ptr_hi);
            instr_pc_d = instr_pc_q + PC_BITS'(4);
          end
          case ({accept, consume})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(2);
            2'b11:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
          endcase
        end
      end
      default: state_d = RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= RESET_HOLD;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // Storage is cleared on reset so instr_o is never X, even when not valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept && !flush_i) begin
      mem_q[wr_ptr_q] <= fetch_data_i;
    end
  end

endmodule

// File: doc/tinyqv_fetch_buffer.md
Name: tinyqv_fetch_buffer

Overview:
Instruction fetch buffer sitting directly upstream of the instruction decoder. It accepts 16-bit halfwords streamed from the memory controller and queues them in a small FIFO. It presents complete 32-bit instructions, with their PC, to the decoder under a valid/ready handshake. It also handles pipeline flushes from branches and jumps, redirecting the fetch address and discarding stale data.

Parameters:
PC_BITS, 24, width of fetch address and PC (byte address).
DEPTH, 4, FIFO capacity in halfwords; must be an even number, at least 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rstn  input  1  asynchronous active-low reset.
flush  input  1  redirect request; single-cycle pulse; highest priority.
flush_pc  input  PC_BITS  new PC on flush; bits [1:0] ignored (treated as 0).
fetch_req  output  1  buffer can accept a halfword this cycle.
fetch_addr  output  PC_BITS  byte address of next halfword to fetch; bit 0 always 0.
fetch_restart  output  1  tells memory controller to abort and restart at fetch_addr.
fetch_data  input  16  returned halfword.
fetch_data_valid  input  1  fetch_data valid; legal only while fetch_req=1.
instr  output  32  {second halfword, first halfword} at FIFO head.
instr_pc  output  PC_BITS  byte PC of instr.
instr_valid  output  1  instr/instr_pc valid.
instr_illegal  output  1  instr_valid and instr[1:0]!=2'b11 (compressed/illegal; not supported).
instr_ready  input  1  decoder consumes instr when instr_valid && instr_ready.

Behaviour:
- State machine, 2 states:
  - RESET_HOLD: entered asynchronously while rstn=0, and held for the first clock edge after release.
  - RUN: all other time; exited only by reset.
  - fetch_req=0 in RESET_HOLD.
- Reset values:
  - count=0, fetch_addr=0, instr_pc=0.
  - fetch_req=0, fetch_restart=0, instr_valid=0, instr_illegal=0.
  - instr=0: FIFO storage is cleared on reset.
- Combinational outputs:
  - fetch_req = RUN && !flush && count<DEPTH.
  - instr_valid = RUN && !flush && count>=2.
  - fetch_restart = flush (same cycle, unregistered).
- Accept: fetch_data_valid && fetch_req.
  - Write fetch_data at the tail.
  - fetch_addr += 2, modulo 2^PC_BITS (wraps 0xFFFFFE -> 0x000000 at PC_BITS=24).
- Consume: instr_valid && instr_ready.
  - Pop two halfwords.
  - instr_pc += 4, modulo 2^PC_BITS.
- Simultaneous accept and consume: the count change is +1-2 = -1. The halfword written must not be lost even when count=2 before the cycle (FIFO pointers, no shifting ambiguity).
- Zero latency from arrival to output: the second halfword arriving at edge N makes instr_valid=1 in cycle N+1.
- Flush (priority over accept and consume):
  - count<=0.
  - fetch_addr<=instr_pc<={flush_pc[PC_BITS-1:2],2'b00}.
  - Any fetch_data_valid in the flush cycle is discarded.
  - instr_ready in the flush cycle is ignored.
  - fetch_req resumes the cycle after.
- fetch_data_valid while fetch_req=0: data dropped, no state change (bench flags it as a protocol error).
- Full (count=DEPTH): fetch_req=0 until a consume.
- Empty or count=1: instr_valid=0. instr contents are don't-care but must be X-free after reset.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), discarding buffered halfwords.

Test Plan:
- Reset release, memory supplies 0x0513, 0x0010 (addi a0,x0,1 low/high halfwords) -> fetch_req=0 one cycle, then 1. fetch_addr goes 0 -> 2 -> 4. Next cycle instr=0x00100513, instr_pc=0, instr_valid=1, instr_illegal=0.
- Decoder holds instr_ready=0 while memory streams -> fetch_req drops after 4 halfwords (DEPTH=4), fetch_addr=8. Raise instr_ready -> instr_pc 0 then 4, fetch_req reasserts.
- count=3 with accept and consume in the same cycle -> count becomes 2. Next instr is formed from halfword 3 and the new halfword, with no data loss, at instr_pc=4.
- flush with flush_pc=0x001236 while fetch_data_valid=1 and count=2 -> fetch_restart=1 that cycle, incoming data dropped. Next cycle fetch_addr=0x001234, instr_pc=0x001234, instr_valid=0.
- fetch_addr at 0xFFFFFC, two halfwords accepted -> fetch_addr=0x000000. Instr consumed -> instr_pc wraps from 0xFFFFFC to 0x000000.
- Halfwords 0x4501, 0x0000 -> instr_valid=1, instr_illegal=1. rstn pulsed low mid-stream -> all outputs 0 immediately.
